// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver and transmitter.
//   rx_state_t - receiver FSM states
//   calc_div   - clocks per bit for a given clock frequency and line rate
//   calc_half  - clocks per half bit (mid-bit sample offset for the start bit)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int calc_half(input int clk_freq, input int baud);
        return calc_div(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for asynchronous input pins.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset; both flops load PRESET
//   d      in  asynchronous input
//   q      out synchronised output (two clocks of latency)
module sync2 #(
    parameter logic PRESET = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= PRESET;
            s2_q <= PRESET;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, for the memory-mapped UART registers.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   RX         in   serial line (asynchronous, idle high)
//   clr_rdy    in   core has read rx_data; clears rdy and overrun
//   rx_data    out  last good byte received
//   rdy        out  rx_data holds an unread byte
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   overrun    out  sticky: a good byte completed while rdy was already set
//   busy       out  frame in progress
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int BAUD_DIV = calc_div(CLK_FREQ, BAUD);
    localparam int HALF_DIV = calc_half(CLK_FREQ, BAUD);
    localparam int CNT_W    = $clog2(BAUD_DIV);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic rx_s;

    sync2 #(.PRESET(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (RX),
        .q     (rx_s)
    );

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rdy_q, rdy_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             good_byte;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        good_byte   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            // Re-check the line at mid start bit so short glitches are dropped.
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // Counter was cleared mid start bit, so a full bit later lands mid data bit.
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // Leave at mid stop bit: the next start edge may follow immediately.
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        good_byte = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // A held-low line must go high before another start is accepted.
            BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Completion takes priority over a same-cycle clear; that clear then
    // counts as having read the previous byte, so no overrun is raised.
    always_comb begin
        rx_data_d = rx_data_q;
        rdy_d     = rdy_q;
        overrun_d = overrun_q;
        if (good_byte) begin
            rx_data_d = shift_q;
            rdy_d     = 1'b1;
            overrun_d = overrun_q | (rdy_q & ~clr_rdy);
        end else if (clr_rdy) begin
            rdy_d     = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rdy_q       <= rdy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rdy       = rdy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule
